// File: rtl/scan_chain_ctrl.sv
// Purpose : scan-chain initiator; loads a pattern, fires one capture cycle, unloads the response.
// Latency : start accepted at edge k -> o_done high after edge k+2*CHAIN_LEN+2; all outputs registered.
// Backpr. : none; i_start is sampled only in IDLE and ignored (not queued) while busy.
// Optional: define SCAN_CHAIN_CTRL_CMP_EN to add response-vs-expected compare and an error counter.
module scan_chain_ctrl #(
    parameter int   CHAIN_LEN = 4,
    parameter logic FILL_BIT  = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_start,
    input  logic [CHAIN_LEN-1:0] i_pattern,
`ifdef SCAN_CHAIN_CTRL_CMP_EN
    input  logic [CHAIN_LEN-1:0] i_expected,
    output logic                 o_mismatch,
    output logic [7:0]           o_err_cnt,
`endif
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CHAIN_LEN-1:0] o_response,
    output logic                 o_scan_en,
    output logic                 o_scan_in,
    input  logic                 i_scan_out
);

    localparam int             CW   = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0]  LAST = CW'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, UNLOAD, DONE} state_t;

    state_t                 r_state;
    state_t                 w_nxt;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    // Holds the pattern bits still to be shifted; the MSB goes straight to scan_in at acceptance.
    logic [CHAIN_LEN-2:0]   r_ld_sr;
    logic [CHAIN_LEN-1:0]   r_resp_sr;
    logic [CHAIN_LEN-1:0]   r_response;
    logic                   r_scan_en;
    logic                   r_scan_in;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_scan_en;
    logic                   w_scan_in;
    logic                   w_busy;
    logic                   w_done;

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) r_state <= IDLE;
        else         r_state <= w_nxt;
    end

    // Next-state logic: phase lengths are set by the bit counter, which restarts on each phase entry
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start)      w_nxt = LOAD;
            LOAD:    if (r_cnt == LAST) w_nxt = CAPTURE;
            CAPTURE:                   w_nxt = UNLOAD;
            UNLOAD:  if (r_cnt == LAST) w_nxt = DONE;
            DONE:                      w_nxt = IDLE;
            default:                   w_nxt = IDLE;
        endcase
    end

    // Output decode: computed from the next state so the registered pins line up with the phase
    always_comb begin
        w_scan_en = (w_nxt == LOAD) || (w_nxt == UNLOAD);
        w_scan_in = 1'b0;
        if (w_nxt == LOAD)
            w_scan_in = (r_state == IDLE) ? i_pattern[CHAIN_LEN-1] : r_ld_sr[CHAIN_LEN-2];
        else if (w_nxt == UNLOAD)
            w_scan_in = FILL_BIT;
        w_busy    = (w_nxt != IDLE);
        w_done    = (r_state == DONE);
        w_cnt_nxt = '0;
        if ((r_state == LOAD && w_nxt == LOAD) || (r_state == UNLOAD && w_nxt == UNLOAD))
            w_cnt_nxt = r_cnt + CW'(1);
    end

    // Output registers, bit counter and load/unload shift registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt      <= '0;
            r_ld_sr    <= '0;
            r_resp_sr  <= '0;
            r_response <= '0;
            r_scan_en  <= 1'b0;
            r_scan_in  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_scan_en <= w_scan_en;
            r_scan_in <= w_scan_in;
            r_busy    <= w_busy;
            r_done    <= w_done;
            if (r_state == IDLE && i_start)
                r_ld_sr <= i_pattern[CHAIN_LEN-2:0];
            else if (r_state == LOAD)
                r_ld_sr <= r_ld_sr << 1;
            // scan_out is the pre-shift value of the last stage, so the first sample lands in the MSB
            if (r_state == UNLOAD)
                r_resp_sr <= {r_resp_sr[CHAIN_LEN-2:0], i_scan_out};
            if (r_state == DONE)
                r_response <= r_resp_sr;
        end
    end

`ifdef SCAN_CHAIN_CTRL_CMP_EN
    logic [CHAIN_LEN-1:0] r_expected;
    logic                 r_mismatch;
    logic [7:0]           r_err_cnt;
    logic                 w_mis;

    assign w_mis = (r_resp_sr != r_expected);

    // Compare the unloaded response against the expectation latched with start; count failures
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_expected <= '0;
            r_mismatch <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (r_state == IDLE && i_start)
                r_expected <= i_expected;
            if (r_state == DONE) begin
                r_mismatch <= w_mis;
                if (w_mis && r_err_cnt != 8'hFF)
                    r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign o_mismatch = r_mismatch;
    assign o_err_cnt  = r_err_cnt;
`endif

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_response = r_response;
    assign o_scan_en  = r_scan_en;
    assign o_scan_in  = r_scan_in;

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Initiator side of the scan-chain interface: drives scan_en/scan_in into a scan register chain (scan_reg instances) and collects scan_out.
- Runs one complete test per request: load a stimulus pattern by shifting, do one functional capture cycle, then shift out the captured response.
- Presents the response as a parallel vector with a done pulse.
- Sits between a test sequencer or testbench and the DUT scan chain.

Parameters:
- CHAIN_LEN, 4, number of flops in the attached scan chain (≥2).
- FILL_BIT, 1'b0, value driven on scan_in during the unload phase.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  request a test; sampled only in IDLE.
- pattern  input  CHAIN_LEN  stimulus vector; sampled on the edge where start is accepted.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; response valid.
- response  output  CHAIN_LEN  captured chain contents; held until the next accepted start.
- scan_en  output  1  to chain: 1 = shift, 0 = functional/capture.
- scan_in  output  1  serial data to chain.
- scan_out  input  1  serial data from the last chain stage.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE; scan_en=0, scan_in=0, busy=0, done=0, response=0; counters=0.
  - Reset mid-test aborts immediately, with no done pulse.
- All outputs are registered.
- Chain orientation: scan_in enters stage 0 and shifts toward stage CHAIN_LEN-1, which drives scan_out.
- Load order: pattern[CHAIN_LEN-1] is shifted first, so after CHAIN_LEN shifts chain data_out == pattern.
- FSM states: IDLE, LOAD, CAPTURE, UNLOAD, DONE.
- IDLE:
  - start=1 at edge k → latch pattern into the shift register, clear the bit counter, go to LOAD.
  - scan_en=1 and scan_in=pattern[CHAIN_LEN-1] from edge k; busy=1.
- LOAD:
  - scan_en=1 for exactly CHAIN_LEN cycles.
  - scan_in advances MSB-first, one bit per edge.
  - On the CHAIN_LEN-th edge, go to CAPTURE.
- CAPTURE:
  - scan_en=0 for exactly one cycle; the chain loads its data_in.
  - scan_in=0.
  - Then go to UNLOAD.
- UNLOAD:
  - scan_en=1, scan_in=FILL_BIT, for CHAIN_LEN cycles.
  - At each shifting edge, sample scan_out (the pre-shift value): resp_sr <= {resp_sr[CHAIN_LEN-2:0], scan_out}.
  - Net effect: response[i] == chain stage i contents after capture.
  - After the CHAIN_LEN-th sample, go to DONE.
- DONE:
  - response <= resp_sr; done=1 for one cycle; scan_en=0; busy=0.
  - Next state IDLE.
- Latency: start accepted at edge k → done high in the cycle after edge k+2·CHAIN_LEN+2. Total busy duration is 2·CHAIN_LEN+2 cycles.
- start while busy is ignored (not queued). start held high through DONE is accepted again only in IDLE, i.e. one cycle after done.
- pattern changes after acceptance have no effect.
- Counter width is $clog2(CHAIN_LEN+1). The counter never wraps: it is reset on each phase entry.
- scan_en never glitches; it changes only on clock edges.

Optional Feature:
- Macro: SCAN_CHAIN_CTRL_CMP_EN.
- Defined:
  - Extra input expected [CHAIN_LEN], sampled with start.
  - Extra outputs:
    - mismatch (1 bit), valid with done: response != expected.
    - err_cnt (8 bits), increments on each done with mismatch=1, saturates at 255.
  - Both outputs reset to 0 asynchronously.
- Undefined: these ports and all associated logic are absent; the rest of the behaviour is identical.

Test Plan:
- Basic load (CHAIN_LEN=4, scan_reg attached, data_in=4'b0000):
  - Stimulus: start with pattern=4'b1011.
  - Required: after the 4th LOAD edge, chain data_out=4'b1011 with scan_en=1 during exactly 4 cycles.
  - Required: capture yields response=4'b0000 and done after 10 cycles.
- Capture/unload:
  - Stimulus: data_in=4'b0011, pattern=4'b1100.
  - Required: response=4'b0011, done pulse exactly 1 cycle.
  - Required: chain holds 4'b0000 afterwards (FILL_BIT=0).
- Start while busy:
  - Stimulus: second start pulse during UNLOAD with pattern=4'b1111.
  - Required: ignored; exactly one done pulse; response from the first test only.
- Reset mid-LOAD:
  - Stimulus: rstn=0 after 2 shift cycles.
  - Required: scan_en, busy, done and response go to 0 asynchronously; no done pulse; a new start after release runs a full 10-cycle test.
- Back-to-back:
  - Stimulus: start held high continuously.
  - Required: consecutive tests separated by one IDLE cycle; each response is correct for its data_in.
- With SCAN_CHAIN_CTRL_CMP_EN:
  - Stimulus: expected=4'b0011 with data_in=4'b0011 → mismatch=0, err_cnt=0.
  - Stimulus: then data_in=4'b0101 → mismatch=1, err_cnt=1.
